// File: rtl/timer_arbiter.sv
// timer_arbiter
// Shares one down-counting interval timer between two requesters.
// A requester raises reqN with a length lenN. The block grants the timer
// round-robin, counts out lenN clk_in cycles (0 is treated as 1), and then
// pulses doneN for one cycle. If the owner drops req while counting, the
// interval is aborted and no done pulse is produced.
//
// Ports:
//   clk_in      system clock; all logic runs on the rising edge
//   rst         synchronous active-high reset
//   req0/req1   timer requests; held high until the matching done pulse
//   len0/len1   requested interval in cycles; sampled only on the grant edge
//   gnt0/gnt1   requester currently owns the timer (one-hot or both zero)
//   done0/done1 single-cycle pulse when the granted interval expires
//   busy        high whenever the timer is not idle
module timer_arbiter #(
    parameter int CNT_W = 26
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             owner;
    logic             owner_next;
    logic             last;
    logic             last_next;

    logic             owner_req;
    logic             grant_valid;
    logic             grant_idx;
    logic [CNT_W-1:0] grant_len;

    // On a tie the requester that was not served last wins; otherwise
    // whichever single request is present is taken.
    always_comb begin
        owner_req   = owner ? req1 : req0;
        grant_valid = req0 | req1;
        grant_idx   = (req0 & req1) ? ~last : req1;
        grant_len   = grant_idx ? len1 : len0;
    end

    // Next-state logic. The counter is loaded with len-1 so that it reaches
    // zero after exactly len COUNT cycles; a zero length loads 0, which makes
    // it behave like a length of one. Decrement only happens from a nonzero
    // value, so the counter can never wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        owner_next = owner;
        last_next  = last;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = COUNT;
                    owner_next = grant_idx;
                    last_next  = grant_idx;
                    cnt_next   = (grant_len == '0) ? '0 : grant_len - CNT_ONE;
                end
            end
            COUNT: begin
                // An abort leaves last pointing at the aborted requester so
                // the other side wins the next tie.
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. last resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            owner <= owner_next;
            last  <= last_next;
        end
    end

    // Outputs are decoded purely from registered state, so there is no
    // combinational path from any input to any output.
    always_comb begin
        busy  = (state != IDLE);
        gnt0  = busy && !owner;
        gnt1  = busy && owner;
        done0 = (state == DONE) && !owner;
        done1 = (state == DONE) && owner;
    end

endmodule
